pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 5-stage IF/ID/EX/MEM/WB MIPS pipeline.
//  Keeps shadow copies of the ID/EX, EX/MEM and MEM/WB register tags. From them it drives forwarding selects,
//  load-use stalls, ID-resolved branch/jump flushes and EX-exception drain/redirect.
//  Sits beside the stage modules; its outputs gate PC and pipeline-register write/flush.
// PARAMETERS
//  REG_AW           5   register address width
//  EXC_DRAIN_CYCLES 2   cycles waited after an EX exception before redirect (MEM+WB retire)
//  PERF_W           16  width of saturating stall counter
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  id_valid       in   1       ID holds a real instruction
//  id_rs, id_rt   in   REG_AW  ID source registers
//  id_uses_rs/rt  in   1       ID instruction reads rs / rt
//  id_dest        in   REG_AW  ID destination (rd or rt, already muxed)
//  id_reg_write   in   1       ID instruction writes register file
//  id_mem_read    in   1       ID instruction is a load
//  id_redirect    in   1       taken branch (equal) or jump resolved in ID
//  ex_exception   in   1       overflow/illegal flagged in EX this cycle
//  mem_busy       in   1       data memory not ready; freeze whole pipe
//  pc_write       out  1       PC register enable
//  if_id_write    out  1       IF/ID register enable
//  if_id_flush    out  1       IF/ID -> bubble
//  id_ex_flush    out  1       ID/EX -> bubble (control bits cleared)
//  ex_mem_flush   out  1       EX/MEM -> bubble
//  pc_sel         out  2       00 PC+4, 01 branch/jump target, 10 exception vector
//  fwd_a, fwd_b   out  2       ALU operand src: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  stall_cnt      out  PERF_W  saturating count of stalled cycles
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RUN, shadows invalid, drain cnt=0, stall_cnt=0.
//   Outputs forced: pc_write=0, if_id_write=0, all flushes=1, pc_sel=00, fwd=00.
//  Shadows: on each unfrozen edge, ID/EX <- {id_valid,rs,rt,dest,reg_write,mem_read}
//   (bubble if id_ex_flush); EX/MEM <- ID/EX; MEM/WB <- EX/MEM. Bubble = valid 0.
//  Forwarding (comb, from ID/EX shadow rs/rt):
//   - EX/MEM match (valid & reg_write & dest!=0 & dest==rs) -> 10.
//   - Else MEM/WB match -> 01. Else 00. EX/MEM wins when both match.
//   - $zero is never forwarded.
//  FSM states RUN, LOAD_STALL, EXC_FLUSH, EXC_REDIRECT. Priority per cycle:
//   mem_busy > exception > load-use > redirect.
//  - mem_busy=1 (any state): pc_write=if_id_write=0, no flush.
//     Shadows, state, drain cnt hold. stall_cnt++.
//  - RUN, ex_exception & ID/EX valid: flush IF/ID, ID/EX, EX/MEM; pc_write=0.
//     drain cnt<=EXC_DRAIN_CYCLES; ->EXC_FLUSH.
//  - RUN, load-use (ID/EX valid & mem_read & dest!=0 & dest matches a used id_rs/id_rt):
//     pc_write=if_id_write=0, id_ex_flush=1, stall_cnt++; ->LOAD_STALL.
//     A simultaneous id_redirect is ignored; it is re-evaluated after the stall.
//  - LOAD_STALL: exactly one cycle; normal RUN rules apply; ->RUN.
//  - RUN/LOAD_STALL, id_redirect (no stall): pc_sel=01, if_id_flush=1, pc_write=1.
//  - EXC_FLUSH: pc_write=0, if_id/id_ex flush=1, ex_exception ignored.
//     cnt-- per unfrozen cycle; cnt==1 -> EXC_REDIRECT.
//  - EXC_REDIRECT: one cycle; pc_sel=10, pc_write=1, if_id_flush=1; ->RUN.
//  - Default (RUN, no event): pc_write=if_id_write=1, flushes 0, pc_sel=00.
//  - stall_cnt saturates at all-ones; no wrap.
//  - Reset mid-drain: immediate return to RUN; no redirect issued.
// STRUCTURE
//  pipe_ctrl_pkg:
//   - ctrl_state_e enum.
//   - FWD_REG/FWD_EXMEM/FWD_MEMWB and PC_SEQ/PC_BR/PC_EXC localparams.
//   - shadow_tag_t struct {valid, rs, rt, dest, reg_write, mem_read}.
//  Sub-module hazard_fwd_unit: purely combinational match/forward/load-use logic.
//  pipeline_ctrl owns the FSM, shadows and counters.
// TESTING
//  1 lw $2 in ID/EX, ID add uses rs=$2
//     -> one cycle pc_write=0, id_ex_flush=1; next cycle fwd_a=01.
//  2 EX/MEM dest=$3 and MEM/WB dest=$3, ID/EX rs=$3 -> fwd_a=10.
//     Same with dest=$0 -> fwd_a=00.
//  3 id_redirect=1 in RUN -> same cycle pc_sel=01, if_id_flush=1.
//     With concurrent load-use -> pc_sel=00; redirect honoured next cycle.
//  4 ex_exception=1 -> 3 flushes same cycle; EXC_FLUSH for 2 cycles.
//     Then pc_sel=10 for 1 cycle; back to RUN.
//  5 mem_busy=1 for 3 cycles during EXC_FLUSH -> drain stretched by 3.
//     stall_cnt +3; shadow tags unchanged.
//  6 rst_n low mid-EXC_FLUSH -> outputs to reset values immediately.
//     After release: RUN, fwd=00, stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/sequencing controller.
// Pure declarations: no logic, no latency.
package pipe_ctrl_pkg;

    localparam int TAG_AW = 5;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        LOAD_STALL   = 2'd1,
        EXC_FLUSH    = 2'd2,
        EXC_REDIRECT = 2'd3
    } ctrl_state_e;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_EXC = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] rs;
        logic [TAG_AW-1:0] rt;
        logic [TAG_AW-1:0] dest;
        logic              reg_write;
        logic              mem_read;
    } shadow_tag_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_fwd_unit.sv
// Forwarding selects and load-use detection from the shadow stage tags.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  shadow_tag_t       idex,
    input  shadow_tag_t       exmem,
    input  shadow_tag_t       memwb,
    input  logic [TAG_AW-1:0] id_rs,
    input  logic [TAG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              load_use
);

    function automatic logic wr_match(input shadow_tag_t t, input logic [TAG_AW-1:0] r);
        return t.valid && t.reg_write && (t.dest != '0) && (t.dest == r);
    endfunction

    // Younger producer (EX/MEM) holds the newer value, so it wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic [TAG_AW-1:0] r,
                                           input shadow_tag_t em,
                                           input shadow_tag_t mw);
        if (wr_match(em, r))      return FWD_EXMEM;
        else if (wr_match(mw, r)) return FWD_MEMWB;
        else                      return FWD_REG;
    endfunction

    assign fwd_a = fwd_sel(idex.rs, exmem, memwb);
    assign fwd_b = fwd_sel(idex.rt, exmem, memwb);

    assign load_use = idex.valid && idex.mem_read && (idex.dest != '0) &&
                      ((id_uses_rs && (idex.dest == id_rs)) ||
                       (id_uses_rt && (idex.dest == id_rt)));

    logic unused_ok;
    assign unused_ok = ^{idex.reg_write, exmem.rs, exmem.rt, exmem.mem_read,
                         memwb.rs, memwb.rt, memwb.mem_read};

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller: shadow stage tags, stall/flush/redirect FSM, stall counter.
// Latency: enables/flushes/pc_sel are combinational from state+inputs; state and shadows update each edge.
// Backpressure: mem_busy freezes PC, IF/ID, shadows, state and drain counter (stall_cnt still counts).
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW           = TAG_AW,
    parameter int EXC_DRAIN_CYCLES = 2,
    parameter int PERF_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_redirect,
    input  logic              ex_exception,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        pc_sel,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam int CW = $clog2(EXC_DRAIN_CYCLES + 1);

    ctrl_state_e state;
    logic [CW-1:0] drain_cnt;
    shadow_tag_t idex, exmem, memwb;
    logic load_use, exc_take, load_stall;

    hazard_fwd_unit u_hazard (
        .idex       (idex),
        .exmem      (exmem),
        .memwb      (memwb),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .load_use   (load_use)
    );

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_sel       = PC_SEQ;
        exc_take     = 1'b0;
        load_stall   = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else begin
            case (state)
                RUN, LOAD_STALL: begin
                    if (ex_exception && idex.valid) begin
                        exc_take     = 1'b1;
                        pc_write     = 1'b0;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (load_use) begin
                        // Redirect is dropped here; the held ID instruction re-raises it next cycle.
                        load_stall  = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (id_redirect) begin
                        pc_sel      = PC_BR;
                        if_id_flush = 1'b1;
                    end
                end
                EXC_FLUSH: begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    pc_sel      = PC_EXC;
                    if_id_flush = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
            idex      <= '0;
            exmem     <= '0;
            memwb     <= '0;
            stall_cnt <= '0;
        end else if (mem_busy) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end else begin
            idex  <= id_ex_flush ? shadow_tag_t'('0)
                                 : '{id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read};
            exmem <= ex_mem_flush ? shadow_tag_t'('0) : idex;
            memwb <= exmem;
            if (load_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            case (state)
                RUN, LOAD_STALL: begin
                    if (exc_take) begin
                        state     <= EXC_FLUSH;
                        drain_cnt <= CW'(EXC_DRAIN_CYCLES);
                    end else if (load_stall) begin
                        state <= LOAD_STALL;
                    end else begin
                        state <= RUN;
                    end
                end
                EXC_FLUSH: begin
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt == CW'(1)) state <= EXC_REDIRECT;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl with hand-computed expectations.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_redirect, ex_exception, mem_busy;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0] pc_sel, fwd_a, fwd_b;
    logic [3:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_AW(5), .EXC_DRAIN_CYCLES(2), .PERF_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_redirect  (id_redirect),
        .ex_exception (ex_exception),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .pc_sel       (pc_sel),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_id(input int v, input int rs, input int rt, input int urs,
                          input int urt, input int dest, input int rw, input int mr);
        id_valid     = v[0];
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_uses_rs   = urs[0];
        id_uses_rt   = urt[0];
        id_dest      = 5'(dest);
        id_reg_write = rw[0];
        id_mem_read  = mr[0];
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        id_redirect = 1'b0;
        ex_exception = 1'b0;
        mem_busy = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("rst_pc_write", int'(pc_write), 0);
        chk("rst_if_id_write", int'(if_id_write), 0);
        chk("rst_flushes", int'({if_id_flush, id_ex_flush, ex_mem_flush}), 7);
        chk("rst_pc_sel", int'(pc_sel), 0);
        chk("rst_fwd", int'({fwd_a, fwd_b}), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("run_default_pc_write", int'(pc_write), 1);
        chk("run_default_flush", int'({if_id_flush, id_ex_flush, ex_mem_flush}), 0);

        // load-use: lw $2 then add $5,$2,$4
        set_id(1, 1, 2, 1, 0, 2, 1, 1);
        step();
        set_id(1, 2, 4, 1, 1, 5, 1, 0);
        #1;
        chk("lu_pc_write", int'(pc_write), 0);
        chk("lu_if_id_write", int'(if_id_write), 0);
        chk("lu_id_ex_flush", int'(id_ex_flush), 1);
        step();
        #1;
        chk("lu_after_pc_write", int'(pc_write), 1);
        chk("lu_after_id_ex_flush", int'(id_ex_flush), 0);
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("lu_fwd_a_memwb", int'(fwd_a), 1);
        chk("lu_fwd_b_none", int'(fwd_b), 0);
        step();

        // EX/MEM and MEM/WB both write $3; consumer reads $3,$3
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        step();
        set_id(1, 7, 0, 1, 0, 3, 1, 0);
        #1;
        chk("fwd_rs0_none", int'(fwd_a), 0);
        step();
        set_id(1, 3, 3, 1, 1, 8, 1, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        mem_busy = 1'b1;
        #1;
        chk("fwd_a_exmem_wins", int'(fwd_a), 2);
        chk("fwd_b_exmem_wins", int'(fwd_b), 2);
        chk("busy_pc_write", int'(pc_write), 0);
        chk("busy_if_id_write", int'(if_id_write), 0);
        chk("busy_no_flush", int'({if_id_flush, id_ex_flush, ex_mem_flush}), 0);
        step();
        mem_busy = 1'b0;
        set_id(1, 0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("busy_shadow_hold_fwd_a", int'(fwd_a), 2);
        chk("busy_stall_cnt", int'(stall_cnt), 2);
        step();
        set_id(1, 0, 0, 0, 0, 0, 1, 0);
        step();
        set_id(1, 0, 0, 1, 1, 8, 1, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fwd_a_zero_reg", int'(fwd_a), 0);
        chk("fwd_b_zero_reg", int'(fwd_b), 0);
        step();

        // redirect alone, then redirect colliding with load-use
        set_id(1, 0, 0, 0, 0, 0, 0, 0);
        id_redirect = 1'b1;
        #1;
        chk("br_pc_sel", int'(pc_sel), 1);
        chk("br_if_id_flush", int'(if_id_flush), 1);
        chk("br_pc_write", int'(pc_write), 1);
        step();
        id_redirect = 1'b0;
        set_id(1, 1, 0, 1, 0, 6, 1, 1);
        step();
        set_id(1, 6, 0, 1, 1, 0, 0, 0);
        id_redirect = 1'b1;
        #1;
        chk("br_lu_pc_sel", int'(pc_sel), 0);
        chk("br_lu_pc_write", int'(pc_write), 0);
        chk("br_lu_id_ex_flush", int'(id_ex_flush), 1);
        chk("br_lu_if_id_flush", int'(if_id_flush), 0);
        step();
        #1;
        chk("br_retry_pc_sel", int'(pc_sel), 1);
        chk("br_retry_if_id_flush", int'(if_id_flush), 1);
        chk("br_retry_pc_write", int'(pc_write), 1);
        step();

        // exception with the branch in ID/EX
        id_redirect = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_exception = 1'b1;
        #1;
        chk("exc_flushes", int'({if_id_flush, id_ex_flush, ex_mem_flush}), 7);
        chk("exc_pc_write", int'(pc_write), 0);
        step();
        #1;
        chk("exc_drain1_pc_write", int'(pc_write), 0);
        chk("exc_drain1_flushes", int'({if_id_flush, id_ex_flush, ex_mem_flush}), 6);
        chk("exc_drain1_pc_sel", int'(pc_sel), 0);
        step();
        ex_exception = 1'b0;
        #1;
        chk("exc_drain2_pc_write", int'(pc_write), 0);
        chk("exc_drain2_pc_sel", int'(pc_sel), 0);
        step();
        #1;
        chk("exc_redirect_pc_sel", int'(pc_sel), 2);
        chk("exc_redirect_pc_write", int'(pc_write), 1);
        chk("exc_redirect_if_id_flush", int'(if_id_flush), 1);
        step();
        #1;
        chk("exc_back_run_pc_sel", int'(pc_sel), 0);
        chk("exc_back_run_if_id_flush", int'(if_id_flush), 0);

        // exception drain stretched by mem_busy
        set_id(1, 0, 0, 0, 0, 9, 1, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_exception = 1'b1;
        step();
        ex_exception = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain_busy_pc_write", int'(pc_write), 0);
            chk("drain_busy_no_flush", int'({if_id_flush, id_ex_flush}), 0);
            step();
        end
        mem_busy = 1'b0;
        #1;
        chk("drain_busy_stall_cnt", int'(stall_cnt), 6);
        chk("drain_stretch1_pc_sel", int'(pc_sel), 0);
        chk("drain_stretch1_if_id_flush", int'(if_id_flush), 1);
        step();
        #1;
        chk("drain_stretch2_pc_sel", int'(pc_sel), 0);
        chk("drain_stretch2_pc_write", int'(pc_write), 0);
        step();
        #1;
        chk("drain_stretch_redirect", int'(pc_sel), 2);
        step();
        #1;
        chk("drain_stretch_run", int'(pc_sel), 0);

        // stall counter saturation (PERF_W=4 -> 15)
        mem_busy = 1'b1;
        for (int i = 0; i < 9; i++) step();
        #1;
        chk("stall_cnt_reach_max", int'(stall_cnt), 15);
        for (int i = 0; i < 3; i++) step();
        #1;
        chk("stall_cnt_saturate", int'(stall_cnt), 15);
        mem_busy = 1'b0;

        // reset in the middle of a drain
        set_id(1, 0, 0, 0, 0, 9, 1, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_exception = 1'b1;
        step();
        ex_exception = 1'b0;
        #1;
        chk("mid_drain_pc_write", int'(pc_write), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc_write", int'(pc_write), 0);
        chk("mid_rst_if_id_write", int'(if_id_write), 0);
        chk("mid_rst_flushes", int'({if_id_flush, id_ex_flush, ex_mem_flush}), 7);
        chk("mid_rst_pc_sel", int'(pc_sel), 0);
        chk("mid_rst_stall_cnt", int'(stall_cnt), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_pc_write", int'(pc_write), 1);
        chk("post_rst_pc_sel", int'(pc_sel), 0);
        chk("post_rst_if_id_flush", int'(if_id_flush), 0);
        chk("post_rst_fwd", int'({fwd_a, fwd_b}), 0);
        chk("post_rst_stall_cnt", int'(stall_cnt), 0);
        step();
        step();
        #1;
        chk("post_rst_no_redirect", int'(pc_sel), 0);
        chk("post_rst_still_run", int'(pc_write), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
